mux_2t1_arbiter: RTL and testbench

- Two-input round-robin arbiter that sits directly upstream of the 2:1 mux.
- It decides which of two valid/ready source channels (A, B) gets through and registers the selected word into a one-entry output stage.
- It exports the select it used, Sel (0 = A, 1 = B), matching the mux convention F = Sel ? B : A.
- It turns the purely combinational mux path into a flow-controlled, single-cycle-throughput stage.

---
 rtl/mux_2t1_arbiter_if.sv | 26 ++
 rtl/mux_2t1_arbiter.sv | 55 +++++
 tb/tb_mux_2t1_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mux_2t1_arbiter_if.sv
// Valid/ready bundle for the two-source round-robin arbiter feeding a 2:1 mux.
// The master modport is the arbiter side; the slave modport is the sources/sink side.
interface mux_2t1_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic             A_valid;
    logic             A_ready;
    logic [WIDTH-1:0] B;
    logic             B_valid;
    logic             B_ready;
    logic [WIDTH-1:0] F;
    logic             F_valid;
    logic             F_ready;
    logic             Sel;

    modport master (
        input  A, A_valid, B, B_valid, F_ready,
        output A_ready, B_ready, F, F_valid, Sel
    );

    modport slave (
        output A, A_valid, B, B_valid, F_ready,
        input  A_ready, B_ready, F, F_valid, Sel
    );
endinterface

// File: rtl/mux_2t1_arbiter.sv
// Round-robin arbiter for two valid/ready sources with a one-entry registered
// output stage; Sel reports the source of F (0 = A, 1 = B).
module mux_2t1_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    mux_2t1_arbiter_if.master  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] f_q;
    logic             sel_q;
    logic             last_b;
    logic             load;
    logic             grant_b;
    logic             accept;

    // On a tie, the source opposite the last grant wins; last_b resets to 1 so A wins first.
    always_comb begin
        load    = (state == EMPTY) | bus.F_ready;
        grant_b = bus.B_valid & (!bus.A_valid | !last_b);
        accept  = load & !rst & (bus.A_valid | bus.B_valid);
    end

    assign bus.A_ready = load & !rst & !grant_b;
    assign bus.B_ready = load & !rst & grant_b;
    assign bus.F       = f_q;
    assign bus.F_valid = (state == FULL);
    assign bus.Sel     = sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            f_q    <= '0;
            sel_q  <= 1'b0;
            last_b <= 1'b1;
        end else begin
            if (accept) begin
                f_q    <= grant_b ? bus.B : bus.A;
                sel_q  <= grant_b;
                last_b <= grant_b;
            end
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (bus.F_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_2t1_arbiter.sv
// Directed bench for mux_2t1_arbiter: expected words are queued when an accept
// is expected and checked against F while they are held in the output stage.
module tb_mux_2t1_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    logic [8:0] q[$];

    mux_2t1_arbiter_if #(.WIDTH(8)) bus ();

    mux_2t1_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the rising edge, check on the falling edge.
    task automatic step(input logic av, input logic [7:0] a, input logic bv, input logic [7:0] b,
                        input logic fr, input logic ear, input logic ebr);
        logic exp_fv;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.A_valid = av; bus.A = a;
        bus.B_valid = bv; bus.B = b;
        bus.F_ready = fr;
        @(negedge clk);
        exp_fv = (q.size() != 0);
        chk("F_valid", {31'b0, bus.F_valid}, {31'b0, exp_fv});
        if (exp_fv) begin
            chk("F", {24'b0, bus.F}, {24'b0, q[0][7:0]});
            chk("Sel", {31'b0, bus.Sel}, {31'b0, q[0][8]});
            if (fr) void'(q.pop_front());
        end
        chk("A_ready", {31'b0, bus.A_ready}, {31'b0, ear});
        chk("B_ready", {31'b0, bus.B_ready}, {31'b0, ebr});
        if (av && ear) q.push_back({1'b0, a});
        if (bv && ebr) q.push_back({1'b1, b});
    endtask

    // Hold rst for n cycles, then one quiet cycle that checks the reset values.
    task automatic do_reset(input int unsigned n, input logic av, input logic bv, input logic fr);
        q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            bus.A_valid = av; bus.B_valid = bv; bus.F_ready = fr;
            @(negedge clk);
            chk("rst_A_ready", {31'b0, bus.A_ready}, 32'd0);
            chk("rst_B_ready", {31'b0, bus.B_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.A_valid = 1'b0; bus.B_valid = 1'b0; bus.F_ready = 1'b1;
        @(negedge clk);
        chk("rst_F", {24'b0, bus.F}, 32'd0);
        chk("rst_F_valid", {31'b0, bus.F_valid}, 32'd0);
        chk("rst_Sel", {31'b0, bus.Sel}, 32'd0);
    endtask

    initial begin
        bus.A = '0; bus.A_valid = 1'b0;
        bus.B = '0; bus.B_valid = 1'b0;
        bus.F_ready = 1'b0;

        do_reset(2, 1'b1, 1'b1, 1'b1);

        // Contention: alternating grants starting with A.
        for (int unsigned i = 0; i < 6; i++)
            step(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, (i % 2) == 0, (i % 2) == 1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Single source A, one word per cycle.
        for (int unsigned i = 0; i < 5; i++)
            step(1'b1, 8'h3C + 8'(i), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Backpressure: hold 0x11, then drain and load on the same edge.
        step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 3; i++)
            step(1'b1, 8'h22, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);

        // Idle cycles leave the pointer on B, so A wins the next tie.
        step(1'b0, 8'h00, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 4; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hC1, 1'b1, 8'hC2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 8'hC4, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Reset while 0x99 is held under backpressure; it must never reappear.
        step(1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        do_reset(1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        chk("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
